apb_master_mux: RTL

Parametrised APB master for the GPIO/UART peripheral subsystem, replacing the fixed two-slave master. Accepts one command at a time over a valid/ready request port. Decodes the target slave from address bits and drives a one-hot PSEL vector of configurable width. Muxes per-slave PRDATA/PREADY/PSLVERR and returns a coded response over a valid/ready response port, with decode-error detection and an optional PREADY timeout.

---
 rtl/apb_master_mux.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/apb_master_mux.sv
// apb_master_mux: single-outstanding APB master with address-decoded slave select.
// Accepts one command over a valid/ready port, runs one APB SETUP/ACCESS transfer on
// the decoded slave, and returns a coded response over a valid/ready port.
// Ports:
//   PCLK, PRESETn                 clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata/strb   command request port
//   rsp_valid/ready/rdata/code    response port (00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT)
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB   APB request outputs
//   PRDATA, PREADY, PSLVERR       per-slave APB returns, slave k in slice k
module apb_master_mux #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned SLAVE_NUM  = 4,
   parameter int unsigned SEL_LSB    = 12,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                            PCLK,
   input  logic                            PRESETn,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [ADDR_WIDTH-1:0]           cmd_addr,
   input  logic [DATA_WIDTH-1:0]           cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]         cmd_strb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic [1:0]                      rsp_code,
   output logic [SLAVE_NUM-1:0]            PSEL,
   output logic                            PENABLE,
   output logic                            PWRITE,
   output logic [ADDR_WIDTH-1:0]           PADDR,
   output logic [DATA_WIDTH-1:0]           PWDATA,
   output logic [DATA_WIDTH/8-1:0]         PSTRB,
   input  logic [SLAVE_NUM*DATA_WIDTH-1:0] PRDATA,
   input  logic [SLAVE_NUM-1:0]            PREADY,
   input  logic [SLAVE_NUM-1:0]            PSLVERR
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned SEL_W  = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
   localparam int unsigned WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] RSP_OK      = 2'b00;
   localparam logic [1:0] RSP_SLVERR  = 2'b01;
   localparam logic [1:0] RSP_DECERR  = 2'b10;
   localparam logic [1:0] RSP_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                  state_q, state_d;
   logic [SEL_W-1:0]        idx_q, idx_d;
   logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
   logic [SEL_W-1:0]        cmd_idx;

   logic                    cmd_ready_d, rsp_valid_d, penable_d, pwrite_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_d, pwdata_d;
   logic [1:0]              rsp_code_d;
   logic [SLAVE_NUM-1:0]    psel_d;
   logic [ADDR_WIDTH-1:0]   paddr_d;
   logic [STRB_W-1:0]       pstrb_d;

   logic [DATA_WIDTH-1:0]   sel_rdata;
   logic                    sel_ready, sel_err;
   logic                    timeout_hit;

   assign cmd_idx = cmd_addr[SEL_LSB +: SEL_W];

   // Select the returns of the addressed slave; all other slaves are ignored.
   always_comb begin
      sel_rdata = '0;
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      for (int unsigned k = 0; k < SLAVE_NUM; k++) begin
         if (idx_q == SEL_W'(k)) begin
            sel_rdata = PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
            sel_ready = PREADY[k];
            sel_err   = PSLVERR[k];
         end
      end
   end

   // Counter is about to reach TIMEOUT on this ACCESS cycle.
   assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == WCNT_W'(TIMEOUT - 1));

   // Next-state and next-output logic; every output is the register of its _d value.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      wcnt_d      = wcnt_q;
      cmd_ready_d = 1'b0;
      rsp_valid_d = rsp_valid;
      rsp_rdata_d = rsp_rdata;
      rsp_code_d  = rsp_code;
      psel_d      = PSEL;
      penable_d   = PENABLE;
      pwrite_d    = PWRITE;
      paddr_d     = PADDR;
      pwdata_d    = PWDATA;
      pstrb_d     = PSTRB;
      unique case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_d = 1'b0;
               idx_d       = cmd_idx;
               if (32'(cmd_idx) >= SLAVE_NUM) begin
                  // Unmapped slave: answer directly, no bus activity.
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_code_d  = RSP_DECERR;
                  rsp_rdata_d = '0;
               end else begin
                  state_d  = SETUP;
                  wcnt_d   = '0;
                  psel_d   = SLAVE_NUM'(1'b1) << cmd_idx;
                  paddr_d  = cmd_addr;
                  pwrite_d = cmd_write;
                  pwdata_d = cmd_write ? cmd_wdata : '0;
                  pstrb_d  = cmd_write ? cmd_strb  : '0;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (sel_ready) begin
               state_d     = RESP;
               psel_d      = '0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_code_d  = sel_err ? RSP_SLVERR : RSP_OK;
               rsp_rdata_d = (!PWRITE && !sel_err) ? sel_rdata : '0;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
               if (timeout_hit) begin
                  state_d     = RESP;
                  psel_d      = '0;
                  penable_d   = 1'b0;
                  rsp_valid_d = 1'b1;
                  rsp_code_d  = RSP_TIMEOUT;
                  rsp_rdata_d = '0;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_code_d  = RSP_OK;
               cmd_ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wcnt_q    <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_code  <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wcnt_q    <= wcnt_d;
         cmd_ready <= cmd_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_code  <= rsp_code_d;
         PSEL      <= psel_d;
         PENABLE   <= penable_d;
         PWRITE    <= pwrite_d;
         PADDR     <= paddr_d;
         PWDATA    <= pwdata_d;
         PSTRB     <= pstrb_d;
      end
   end

endmodule
